code_lock_param: RTL and testbench
==================================

Name: code_lock_param

Overview:
- Parametrised successor to the fixed four-nibble combination-lock FSM.
- Generalises digit width, code length and reset code.
- Adds a ready/valid digit handshake, a bounded retry counter with a timed lockout, and an explicit relock command.
- Removes early-abort behaviour: a verdict is only given after a full-length entry, so no code prefix can be probed and no hidden path exists.
- Sits behind a keypad/debug-access front end; `unlocked` gates a protected resource.

Parameters:
- DIGIT_W, 4, bits per entered digit.
- CODE_LEN, 4, digits per code (>=1).
- RESET_CODE, 16'hC0DE, code after reset, width DIGIT_W*CODE_LEN, first digit in MSBs.
- MAX_TRIES, 3, consecutive failed entries that trigger lockout (>=1).
- LOCKOUT_CYC, 16, lockout duration in clk cycles (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- din  in  DIGIT_W  entered digit.
- din_valid  in  1  digit offered; accepted when din_valid & din_ready at clk edge.
- din_ready  out  1  high only in ENTRY state.
- relock  in  1  abort entry (ENTRY) or relock (UNLOCKED).
- unlocked  out  1  high while in UNLOCKED.
- lockout_active  out  1  high while in LOCKOUT.
- fail_pulse  out  1  one-cycle pulse per failed full entry.
- attempts  out  $clog2(MAX_TRIES+1)  consecutive failed entries.

Behaviour:
- States: ENTRY, UNLOCKED, LOCKOUT. All state is registered; outputs decode state or registers with no combinational path from din.
- Reset (reset_n low, async):
  - state=ENTRY, digit index idx=0, mismatch flag=0, attempts=0, timer=0, code register=RESET_CODE.
  - unlocked=0, lockout_active=0, fail_pulse=0, din_ready=1.
- ENTRY:
  - Each accepted digit is compared with code digit idx (idx 0 = MSB digit). On mismatch, the sticky mismatch flag is set. idx increments.
  - No early rejection: din_ready stays 1 for all CODE_LEN digits regardless of mismatch.
  - On the accepted digit with idx==CODE_LEN-1:
    - All digits match: next state UNLOCKED, attempts cleared. unlocked=1 on the cycle after the accepting edge.
    - Otherwise: fail_pulse=1 for exactly one cycle after the edge, attempts+1, idx/mismatch cleared.
    - If the new attempts == MAX_TRIES: go to LOCKOUT with timer=LOCKOUT_CYC. Else stay in ENTRY.
  - relock=1 clears idx and mismatch, attempts unchanged, no fail_pulse. relock has priority over a same-cycle din_valid; that digit is dropped.
- UNLOCKED:
  - din_ready=0; din ignored.
  - relock=1: next state ENTRY, idx=0, attempts=0; unlocked=0 the next cycle.
- LOCKOUT:
  - din_ready=0; relock ignored.
  - Timer decrements each cycle; lockout_active is high for exactly LOCKOUT_CYC cycles.
  - When the timer reaches 0: ENTRY, attempts=0, idx=0.
- attempts saturates at MAX_TRIES and never wraps.
- fail_pulse is never high in UNLOCKED or LOCKOUT except on the first LOCKOUT cycle, where it is 1 (the failing entry).
- reset_n asserted mid-entry, mid-lockout or while unlocked returns immediately to reset values; code register also returns to RESET_CODE.

Optional Feature:
- Macro: CODE_LOCK_PROG_EN.
- Defined:
  - Adds ports prog_valid (in, 1) and prog_code (in, DIGIT_W*CODE_LEN).
  - In UNLOCKED, prog_valid=1 loads prog_code into the code register at the clk edge.
  - prog_valid is ignored in ENTRY and LOCKOUT.
  - The new code is effective for the next entry; it survives relock but not reset.
- Undefined: ports absent; code register is the constant RESET_CODE.

Test Plan:
All tests use defaults (DIGIT_W=4, CODE_LEN=4, RESET_CODE=C0DE, MAX_TRIES=3, LOCKOUT_CYC=16).
- Correct code: reset, then digits C,0,D,E back-to-back → unlocked=1 one cycle after the 4th accept; attempts=0; fail_pulse never high; din_ready=0 thereafter.
- No early reject: digits F,0,0,F → din_ready=1 for all 4 digits; fail_pulse=1 for one cycle after the 4th; attempts=1; unlocked stays 0.
- Lockout: three wrong entries (1,1,1,1 ×3) → attempts 1,2,3; lockout_active=1 and din_ready=0 for exactly 16 cycles; digits driven during lockout are ignored; then ENTRY with attempts=0, and C,0,D,E unlocks.
- Abort: digits C,0, then relock=1 with din_valid=1, din=D → digit dropped, attempts unchanged; following C,0,D,E unlocks.
- Relock and async reset:
  - While unlocked, relock=1 → unlocked=0 next cycle, din_ready=1.
  - reset_n pulsed low between clk edges mid-entry → outputs reset immediately; entry restarts at idx 0.
- CODE_LOCK_PROG_EN: unlock with C0DE, prog_valid=1 with prog_code=16'h1234, relock → C,0,D,E fails (fail_pulse); 1,2,3,4 unlocks; reset_n then restores C0DE.

Source files
------------

// File: rtl/code_lock_param.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_param
// Purpose  : Parametrised combination lock with a ready/valid digit input,
//            a bounded retry counter, a timed lockout and a relock command.
//            The optional macro CODE_LOCK_PROG_EN adds a programmable code.
// Revision : 1.0  initial release
// ============================================================================
module code_lock_param #(
    parameter int                           DIGIT_W     = 4,
    parameter int                           CODE_LEN    = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0]  RESET_CODE  = 16'hC0DE,
    parameter int                           MAX_TRIES   = 3,
    parameter int                           LOCKOUT_CYC = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [DIGIT_W-1:0]               din,
    input  logic                             din_valid,
    output logic                             din_ready,
    input  logic                             relock,
    output logic                             unlocked,
    output logic                             lockout_active,
    output logic                             fail_pulse,
    output logic [$clog2(MAX_TRIES+1)-1:0]   attempts
`ifdef CODE_LOCK_PROG_EN
    ,
    input  logic                             prog_valid,
    input  logic [DIGIT_W*CODE_LEN-1:0]      prog_code
`endif
);

    localparam int CW = DIGIT_W * CODE_LEN;
    localparam int AW = $clog2(MAX_TRIES + 1);
    localparam int TW = $clog2(LOCKOUT_CYC + 1);
    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            mism_q;
    logic [AW-1:0]   att_q;
    logic [TW-1:0]   timer_q;
    logic            fail_q;
    logic [CW-1:0]   code_q;

    logic [CW-1:0]      code_shift_d;
    logic [DIGIT_W-1:0] exp_digit_d;
    logic               mism_d;
    logic [AW-1:0]      att_inc_d;

`ifndef CODE_LOCK_PROG_EN
    assign code_q = RESET_CODE;
`endif

    // Digit idx 0 lives in the most significant slot of the code word.
    assign code_shift_d = code_q >> (DIGIT_W * (CODE_LEN - 1 - int'(idx_q)));
    assign exp_digit_d  = code_shift_d[DIGIT_W-1:0];
    assign mism_d       = mism_q | (din != exp_digit_d);
    assign att_inc_d    = (att_q >= AW'(MAX_TRIES)) ? att_q : att_q + AW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ENTRY;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            att_q   <= '0;
            timer_q <= '0;
            fail_q  <= 1'b0;
`ifdef CODE_LOCK_PROG_EN
            code_q  <= RESET_CODE;
`endif
        end else begin
            fail_q <= 1'b0;
            case (state_q)
                ST_ENTRY: begin
                    if (relock) begin
                        idx_q  <= '0;
                        mism_q <= 1'b0;
                    end else if (din_valid) begin
                        if (idx_q == IW'(CODE_LEN - 1)) begin
                            idx_q  <= '0;
                            mism_q <= 1'b0;
                            if (!mism_d) begin
                                state_q <= ST_UNLOCKED;
                                att_q   <= '0;
                            end else begin
                                fail_q <= 1'b1;
                                att_q  <= att_inc_d;
                                if (att_inc_d == AW'(MAX_TRIES)) begin
                                    state_q <= ST_LOCKOUT;
                                    timer_q <= TW'(LOCKOUT_CYC);
                                end
                            end
                        end else begin
                            idx_q  <= idx_q + IW'(1);
                            mism_q <= mism_d;
                        end
                    end
                end
                ST_UNLOCKED: begin
`ifdef CODE_LOCK_PROG_EN
                    if (prog_valid) begin
                        code_q <= prog_code;
                    end
`endif
                    if (relock) begin
                        state_q <= ST_ENTRY;
                        idx_q   <= '0;
                        mism_q  <= 1'b0;
                        att_q   <= '0;
                    end
                end
                ST_LOCKOUT: begin
                    // Leaving on the tick that would take the timer to zero
                    // keeps the lockout window exactly LOCKOUT_CYC cycles.
                    if (timer_q <= TW'(1)) begin
                        state_q <= ST_ENTRY;
                        timer_q <= '0;
                        att_q   <= '0;
                        idx_q   <= '0;
                        mism_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= ST_ENTRY;
            endcase
        end
    end

    assign din_ready      = (state_q == ST_ENTRY);
    assign unlocked       = (state_q == ST_UNLOCKED);
    assign lockout_active = (state_q == ST_LOCKOUT);
    assign fail_pulse     = fail_q;
    assign attempts       = att_q;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_param
// Purpose  : Directed plus randomized checks of code_lock_param against a
//            transaction-level model of the lock rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_code_lock_param;

    localparam int          CL = 4;
    localparam int          MT = 3;
    localparam int          LC = 16;
    localparam logic [15:0] RC = 16'hC0DE;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic [3:0] din       = '0;
    logic       din_valid = 1'b0;
    logic       relock    = 1'b0;
    logic       din_ready, unlocked, lockout_active, fail_pulse;
    logic [1:0] attempts;
`ifdef CODE_LOCK_PROG_EN
    logic        prog_valid = 1'b0;
    logic [15:0] prog_code  = '0;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_code = RC;
    int          m_att  = 0;
    bit          m_unl  = 1'b0;

    always #5 clk = ~clk;

    code_lock_param dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .din            (din),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .relock         (relock),
        .unlocked       (unlocked),
        .lockout_active (lockout_active),
        .fail_pulse     (fail_pulse),
        .attempts       (attempts)
`ifdef CODE_LOCK_PROG_EN
        ,
        .prog_valid     (prog_valid),
        .prog_code      (prog_code)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called between clock edges: outputs must clear without waiting for clk.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #2;
        chk({tag, "_unlocked"}, 32'(unlocked), 0);
        chk({tag, "_lockout"},  32'(lockout_active), 0);
        chk({tag, "_fail"},     32'(fail_pulse), 0);
        chk({tag, "_ready"},    32'(din_ready), 1);
        chk({tag, "_attempts"}, 32'(attempts), 0);
        reset_n = 1'b1;
        m_code  = RC;
        m_att   = 0;
        m_unl   = 1'b0;
    endtask

    task automatic send_digits(input logic [15:0] v, input int k);
        logic [15:0] s;
        s = v;
        for (int i = 0; i < k; i++) begin
            din       = s[15:12];
            s         = s << 4;
            din_valid = 1'b1;
            chk("ready_per_digit", 32'(din_ready), 1);
            tick();
            if (i < CL - 1) chk("no_early_verdict", 32'(fail_pulse), 0);
        end
        din_valid = 1'b0;
    endtask

    task automatic lockout_wait();
        int cnt;
        cnt = 1;
        chk("lock_active", 32'(lockout_active), 1);
        chk("lock_ready",  32'(din_ready), 0);
        while (lockout_active === 1'b1 && cnt <= LC + 4) begin
            din       = 4'($urandom);
            din_valid = 1'($urandom);
            relock    = 1'($urandom);
            tick();
            if (lockout_active === 1'b1) begin
                cnt++;
                chk("lock_fail_low",  32'(fail_pulse), 0);
                chk("lock_ready_low", 32'(din_ready), 0);
            end
        end
        din_valid = 1'b0;
        relock    = 1'b0;
        chk("lock_len",        cnt, LC);
        chk("lock_exit_ready", 32'(din_ready), 1);
        chk("lock_exit_att",   32'(attempts), 0);
        chk("lock_exit_unl",   32'(unlocked), 0);
        m_att = 0;
    endtask

    task automatic enter(input logic [15:0] v);
        send_digits(v, CL);
        if (v == m_code) begin
            m_att = 0;
            m_unl = 1'b1;
            chk("ok_unlocked", 32'(unlocked), 1);
            chk("ok_attempts", 32'(attempts), 0);
            chk("ok_fail",     32'(fail_pulse), 0);
            chk("ok_ready",    32'(din_ready), 0);
        end else begin
            m_att++;
            chk("bad_fail",     32'(fail_pulse), 1);
            chk("bad_attempts", 32'(attempts), m_att);
            chk("bad_unlocked", 32'(unlocked), 0);
            if (m_att == MT) begin
                lockout_wait();
            end else begin
                chk("bad_ready", 32'(din_ready), 1);
                tick();
                chk("fail_one_cycle", 32'(fail_pulse), 0);
            end
        end
    endtask

    task automatic relock_unlocked();
        relock = 1'b1;
        tick();
        relock = 1'b0;
        m_unl  = 1'b0;
        m_att  = 0;
        chk("relock_unl",   32'(unlocked), 0);
        chk("relock_ready", 32'(din_ready), 1);
        chk("relock_att",   32'(attempts), 0);
    endtask

    task automatic abort_entry(input logic [15:0] v, input int k, input logic [3:0] drop);
        send_digits(v, k);
        din       = drop;
        din_valid = 1'b1;
        relock    = 1'b1;
        tick();
        din_valid = 1'b0;
        relock    = 1'b0;
        chk("abort_ready", 32'(din_ready), 1);
        chk("abort_att",   32'(attempts), m_att);
        chk("abort_fail",  32'(fail_pulse), 0);
    endtask

    task automatic idle_unlocked(input int n);
        for (int i = 0; i < n; i++) begin
            din       = 4'($urandom);
            din_valid = 1'b1;
            tick();
            chk("unl_hold",  32'(unlocked), 1);
            chk("unl_ready", 32'(din_ready), 0);
        end
        din_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset("rst0");

        // Correct code back-to-back, then din ignored while unlocked.
        enter(16'hC0DE);
        idle_unlocked(3);
        relock_unlocked();

        // Full wrong entry with no early reject.
        enter(16'hF00F);

        // Three wrong entries from a clean start lead to lockout.
        tick();
        do_reset("rst1");
        enter(16'h1111);
        enter(16'h1111);
        enter(16'h1111);
        enter(16'hC0DE);
        relock_unlocked();

        // Abort mid-entry drops the same-cycle digit.
        abort_entry(16'hC0DE, 2, 4'hD);
        enter(16'hC0DE);
        relock_unlocked();

        // Async reset mid-entry with a pending failure count.
        enter(16'h1111);
        send_digits(16'hC0DE, 2);
        do_reset("rst_mid");
        enter(16'hC0DE);
        do_reset("rst_unl");

        // Async reset during lockout.
        enter(16'h2222);
        enter(16'h2222);
        send_digits(16'h2222, CL);
        chk("pre_rst_lock", 32'(lockout_active), 1);
        tick();
        tick();
        do_reset("rst_lock");
        enter(16'hC0DE);
        relock_unlocked();

        // Randomized mix of entries, aborts and relocks.
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (m_unl) begin
                if (r < 3) idle_unlocked(1 + r);
                relock_unlocked();
            end else if (r < 2) begin
                abort_entry(16'($urandom), int'($urandom_range(1, CL - 1)), 4'($urandom));
            end else if (r < 5) begin
                enter(m_code);
            end else begin
                enter(16'($urandom));
            end
        end

`ifdef CODE_LOCK_PROG_EN
        tick();
        do_reset("rst_prog");
        prog_valid = 1'b1;
        prog_code  = 16'h5555;
        tick();
        prog_valid = 1'b0;
        enter(16'hC0DE);
        prog_valid = 1'b1;
        prog_code  = 16'h1234;
        tick();
        prog_valid = 1'b0;
        chk("prog_unl", 32'(unlocked), 1);
        relock_unlocked();
        m_code = 16'h1234;
        enter(16'hC0DE);
        enter(16'h1234);
        relock_unlocked();
        do_reset("rst_prog2");
        enter(16'hC0DE);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
